cpu_dmem_bridge: RTL and testbench



---
 rtl/cpu_dmem_bridge_pkg.sv | 25 ++
 rtl/dmem_addr_decode.sv | 23 ++
 rtl/cpu_dmem_bridge.sv | 144 ++++++++++++++
 tb/tb_cpu_dmem_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dmem_bridge_pkg.sv
// rtl/cpu_dmem_bridge_pkg.sv - shared region, FSM and read-select encodings for the data-memory bridge
package cpu_dmem_bridge_pkg;

    localparam int unsigned    RAM_AW_DEFAULT   = 12;
    localparam logic [3:0]     PER_BASE_DEFAULT = 4'hF;
    localparam int unsigned    TIMEOUT_DEFAULT  = 255;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_PER  = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        RSEL_ZERO = 1'b0,
        RSEL_RAM  = 1'b1
    } rsel_t;

endpackage

// File: rtl/dmem_addr_decode.sv
// rtl/dmem_addr_decode.sv - combinational region decode of the CPU data address
module dmem_addr_decode
    import cpu_dmem_bridge_pkg::*;
#(
    parameter int unsigned RAM_AW   = RAM_AW_DEFAULT,
    parameter logic [3:0]  PER_BASE = PER_BASE_DEFAULT
) (
    input  logic [31:RAM_AW+2] addr_hi,
    output region_t            region
);

    // RAM wins if both ever matched, which only happens with PER_BASE == 0
    always_comb begin
        if (addr_hi == '0) begin
            region = REG_RAM;
        end else if (addr_hi[31:28] == PER_BASE) begin
            region = REG_PER;
        end else begin
            region = REG_NONE;
        end
    end

endmodule

// File: rtl/cpu_dmem_bridge.sv
// rtl/cpu_dmem_bridge.sv - CPU data port bridge to block RAM and a stalling peripheral bus
module cpu_dmem_bridge
    import cpu_dmem_bridge_pkg::*;
#(
    parameter int unsigned RAM_AW   = RAM_AW_DEFAULT,
    parameter logic [3:0]  PER_BASE = PER_BASE_DEFAULT,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              per_valid,
    output logic              per_we,
    output logic [3:0]        per_be,
    output logic [27:0]       per_addr,
    output logic [31:0]       per_wdata,
    input  logic [31:0]       per_rdata,
    input  logic              per_ready,
    output logic              bus_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    region_t     region;
    state_t      state;
    state_t      state_next;
    rsel_t       rsel;
    rsel_t       rsel_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [31:0] rd_hold;
    logic        req;
    logic        per_start;
    logic        timeout_hit;

    dmem_addr_decode #(
        .RAM_AW   (RAM_AW),
        .PER_BASE (PER_BASE)
    ) u_decode (
        .addr_hi (cpu_addr[31:RAM_AW+2]),
        .region  (region)
    );

    assign req       = cpu_ren | cpu_wen;
    assign per_start = (state == ST_IDLE) && req && (region == REG_PER);
    assign cnt_inc   = cnt + 8'd1;

    assign ram_en    = req && (region == REG_RAM);
    assign ram_we    = (ram_en && cpu_wen) ? cpu_be : 4'b0000;
    assign ram_addr  = ram_en ? cpu_addr[RAM_AW+1:2] : '0;
    assign ram_wdata = ram_en ? cpu_wdata : 32'h0;

    // A combined read+write is treated as a write, so it never selects RAM read data
    assign rsel_next = ((state == ST_IDLE) && ram_en && cpu_ren && !cpu_wen) ? RSEL_RAM : RSEL_ZERO;

    assign cpu_rdata = (state == ST_DONE)   ? rd_hold   :
                       (rsel == RSEL_RAM)   ? ram_rdata : 32'h0;

    always_comb begin
        state_next  = state;
        cpu_ready   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_ready = !per_start;
                if (per_start) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (per_ready) begin
                    state_next = ST_DONE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_next  = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                cpu_ready  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rsel      <= RSEL_ZERO;
            cnt       <= 8'd0;
            rd_hold   <= 32'h0;
            per_valid <= 1'b0;
            per_we    <= 1'b0;
            per_be    <= 4'b0000;
            per_addr  <= 28'h0;
            per_wdata <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            state <= state_next;
            rsel  <= rsel_next;

            if (per_start) begin
                per_valid <= 1'b1;
                per_we    <= cpu_wen;
                per_be    <= cpu_be;
                per_addr  <= cpu_addr[27:0];
                per_wdata <= cpu_wdata;
                cnt       <= 8'd0;
            end

            // Handshake takes priority over a timeout landing on the same cycle
            if (state == ST_WAIT) begin
                if (per_ready) begin
                    per_valid <= 1'b0;
                    rd_hold   <= per_we ? 32'h0 : per_rdata;
                end else if (timeout_hit) begin
                    per_valid <= 1'b0;
                    rd_hold   <= 32'h0;
                    bus_err   <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end

            if ((state == ST_IDLE) && req && ((region == REG_NONE) || (cpu_ren && cpu_wen))) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_dmem_bridge.sv
// tb/tb_cpu_dmem_bridge.sv - directed self-checking bench for cpu_dmem_bridge
module tb_cpu_dmem_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        per_valid;
    logic        per_we;
    logic [3:0]  per_be;
    logic [27:0] per_addr;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata;
    logic        per_ready;
    logic        bus_err;

    int n_chk;
    int n_fail;

    logic [31:0] mem [0:4095];

    cpu_dmem_bridge #(
        .RAM_AW   (12),
        .PER_BASE (4'hF),
        .TIMEOUT  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .per_valid (per_valid),
        .per_we    (per_we),
        .per_be    (per_be),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_ready (per_ready),
        .bus_err   (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block RAM model: byte-enabled write, read data one cycle after ram_en
    always @(posedge clock) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) begin
                    mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        cpu_ren   = ren;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        tick;
        tick;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        ram_rdata = 32'h0;
        per_rdata = 32'h0;
        per_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        tick;
        tick;

        chk("rst_ready",     32'(cpu_ready), 32'h1);
        chk("rst_rdata",     cpu_rdata,      32'h0);
        chk("rst_per_valid", 32'(per_valid), 32'h0);
        chk("rst_per_we",    32'(per_we),    32'h0);
        chk("rst_per_be",    32'(per_be),    32'h0);
        chk("rst_per_addr",  32'(per_addr),  32'h0);
        chk("rst_per_wdata", per_wdata,      32'h0);
        chk("rst_bus_err",   32'(bus_err),   32'h0);
        chk("rst_ram_en",    32'(ram_en),    32'h0);
        chk("rst_ram_we",    32'(ram_we),    32'h0);
        reset = 1'b1;
        tick;

        // RAM write then read
        drive(1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0011);
        chk("t1_ram_en",    32'(ram_en),    32'h1);
        chk("t1_ram_we",    32'(ram_we),    32'h3);
        chk("t1_ram_addr",  32'(ram_addr),  32'h4);
        chk("t1_ram_wdata", ram_wdata,      32'hAABB_CCDD);
        chk("t1_ready_w",   32'(cpu_ready), 32'h1);
        tick;
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b1111);
        chk("t1_ram_we_rd", 32'(ram_we),    32'h0);
        chk("t1_rdata_pre", cpu_rdata,      32'h0);
        chk("t1_ready_r",   32'(cpu_ready), 32'h1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t1_rdata",     cpu_rdata,      32'h0000_CCDD);
        chk("t1_ready_a",   32'(cpu_ready), 32'h1);
        chk("t1_ram_en_0",  32'(ram_en),    32'h0);
        tick;
        chk("t1_rdata_off", cpu_rdata,      32'h0);

        // Peripheral read, per_ready on the third WAIT cycle
        drive(1'b1, 1'b0, 32'hF000_0004, 32'h0, 4'b1111);
        chk("t2_ready_req", 32'(cpu_ready), 32'h0);
        chk("t2_valid_req", 32'(per_valid), 32'h0);
        tick;
        chk("t2_valid_w1",  32'(per_valid), 32'h1);
        chk("t2_addr",      32'(per_addr),  32'h4);
        chk("t2_we",        32'(per_we),    32'h0);
        chk("t2_ready_w1",  32'(cpu_ready), 32'h0);
        tick;
        chk("t2_valid_w2",  32'(per_valid), 32'h1);
        chk("t2_ready_w2",  32'(cpu_ready), 32'h0);
        tick;
        per_ready = 1'b1;
        per_rdata = 32'h1234_5678;
        #1;
        chk("t2_valid_w3",  32'(per_valid), 32'h1);
        chk("t2_ready_w3",  32'(cpu_ready), 32'h0);
        tick;
        per_ready = 1'b0;
        per_rdata = 32'hAAAA_AAAA;
        #1;
        chk("t2_ready_done", 32'(cpu_ready), 32'h1);
        chk("t2_rdata_done", cpu_rdata,      32'h1234_5678);
        chk("t2_valid_done", 32'(per_valid), 32'h0);
        chk("t2_err_done",   32'(bus_err),   32'h0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t2_ready_idle", 32'(cpu_ready), 32'h1);
        chk("t2_rdata_idle", cpu_rdata,      32'h0);

        // Peripheral timeout: DONE after 4 WAIT cycles
        drive(1'b1, 1'b0, 32'hF000_0010, 32'h0, 4'b1111);
        tick;
        tick;
        tick;
        tick;
        chk("t3_ready_w4",  32'(cpu_ready), 32'h0);
        chk("t3_valid_w4",  32'(per_valid), 32'h1);
        chk("t3_err_w4",    32'(bus_err),   32'h0);
        tick;
        chk("t3_ready_done", 32'(cpu_ready), 32'h1);
        chk("t3_rdata_done", cpu_rdata,      32'h0);
        chk("t3_valid_done", 32'(per_valid), 32'h0);
        chk("t3_err_done",   32'(bus_err),   32'h1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        repeat (20) tick;
        chk("t3_err_sticky", 32'(bus_err),   32'h1);
        chk("t3_ready_late", 32'(cpu_ready), 32'h1);

        // Handshake on the timeout cycle wins over the timeout
        do_reset;
        chk("hs_err_rst", 32'(bus_err), 32'h0);
        drive(1'b0, 1'b1, 32'hF000_0100, 32'hDEAD_BEEF, 4'b1100);
        chk("hs_ready_req", 32'(cpu_ready), 32'h0);
        tick;
        chk("hs_per_we",    32'(per_we),    32'h1);
        chk("hs_per_be",    32'(per_be),    32'hC);
        chk("hs_per_wdata", per_wdata,      32'hDEAD_BEEF);
        chk("hs_per_addr",  32'(per_addr),  32'h100);
        tick;
        tick;
        tick;
        per_ready = 1'b1;
        per_rdata = 32'hFFFF_FFFF;
        tick;
        per_ready = 1'b0;
        #1;
        chk("hs_ready_done", 32'(cpu_ready), 32'h1);
        chk("hs_rdata_done", cpu_rdata,      32'h0);
        chk("hs_err",        32'(bus_err),   32'h0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);

        // Reset asserted during WAIT, late per_ready ignored
        drive(1'b1, 1'b0, 32'hF000_0008, 32'h0, 4'b1111);
        tick;
        tick;
        chk("t5_valid_wait", 32'(per_valid), 32'h1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t5_valid_rst", 32'(per_valid), 32'h0);
        chk("t5_ready_rst", 32'(cpu_ready), 32'h1);
        chk("t5_err_rst",   32'(bus_err),   32'h0);
        tick;
        reset = 1'b1;
        per_ready = 1'b1;
        per_rdata = 32'h5555_5555;
        tick;
        per_ready = 1'b0;
        #1;
        chk("t5_ready_a", 32'(cpu_ready), 32'h1);
        chk("t5_rdata_a", cpu_rdata,      32'h0);
        chk("t5_valid_a", 32'(per_valid), 32'h0);
        tick;
        chk("t5_ready_b", 32'(cpu_ready), 32'h1);
        chk("t5_rdata_b", cpu_rdata,      32'h0);
        chk("t5_err_b",   32'(bus_err),   32'h0);

        // Unmapped write and read
        do_reset;
        drive(1'b0, 1'b1, 32'h8000_0000, 32'h1111_1111, 4'b1111);
        chk("t4_ram_en",  32'(ram_en),    32'h0);
        chk("t4_valid",   32'(per_valid), 32'h0);
        chk("t4_ready",   32'(cpu_ready), 32'h1);
        chk("t4_err_pre", 32'(bus_err),   32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b1111);
        chk("t4_err",      32'(bus_err),   32'h1);
        chk("t4_valid_r",  32'(per_valid), 32'h0);
        chk("t4_ready_r",  32'(cpu_ready), 32'h1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t4_rdata",    cpu_rdata,      32'h0);
        chk("t4_ready_a",  32'(cpu_ready), 32'h1);

        // Simultaneous read and write to RAM: write wins, error flagged
        do_reset;
        drive(1'b1, 1'b1, 32'h0000_0020, 32'h0102_0304, 4'b1111);
        chk("t6_ram_en",   32'(ram_en),    32'h1);
        chk("t6_ram_we",   32'(ram_we),    32'hF);
        chk("t6_ram_addr", 32'(ram_addr),  32'h8);
        chk("t6_ready",    32'(cpu_ready), 32'h1);
        tick;
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b1111);
        chk("t6_err",      32'(bus_err),   32'h1);
        chk("t6_rdata_0",  cpu_rdata,      32'h0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t6_rdata",    cpu_rdata,      32'h0102_0304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
